board_frame_sync: RTL and testbench
===================================

// Module: board_frame_sync
// PURPOSE
//  Owns the 4x4 board of tile exponents that feeds the 16 displaytile instances.
//  Game logic writes tiles into a shadow buffer through a valid/ready port.
//  A commit copies the shadow buffer to the display buffer at the start of vertical blanking.
//  The display therefore never shows a half-updated board (no tearing).
//  Sits between the game FSM and the VGA tile renderers; consumes the VGA counters.
// PARAMETERS
//  N_TILES   16   number of tiles, row-major; idx = YIDX*4 + XIDX
//  VAL_W     4    tile exponent width (0 = empty, 1..13 = 2..8192)
//  MAX_VAL   13   largest legal exponent; larger writes are stored as 0
//  V_ACTIVE  480  first non-visible line; vblank starts at counter_y==V_ACTIVE, counter_x==0
// PORTS
//  clk          in   1            system clock
//  rst          in   1            synchronous, active-high reset
//  counter_x    in   10           VGA horizontal counter
//  counter_y    in   10           VGA vertical counter
//  wr_valid     in   1            tile write request
//  wr_ready     out  1            shadow buffer accepts a write this cycle
//  wr_idx       in   4            tile index of the write
//  wr_val       in   VAL_W        exponent to write
//  clr_req      in   1            one-cycle request: zero the whole shadow buffer
//  commit_req   in   1            one-cycle request: publish shadow at next vblank
//  commit_ack   out  1            one-cycle pulse: display buffer updated
//  busy         out  1            commit pending or in progress
//  frame_tick   out  1            one-cycle pulse at each vblank start
//  board_vals   out  N_TILES*VAL_W  display buffer; tile i at [i*VAL_W +: VAL_W]
// BEHAVIOUR
//  Reset:
//   - shadow and board_vals all 0; state IDLE.
//   - wr_ready=0 while rst=1, then 1 in the first cycle after reset.
//   - commit_ack=0, busy=0, frame_tick=0.
//  Vblank detect:
//   - cond = (counter_y==V_ACTIVE && counter_x==0); cond_d is cond delayed one cycle.
//   - frame_tick is registered and equals (cond & ~cond_d) from the previous cycle.
//   - Result: exactly one pulse per frame, even if the counters hold for several clocks.
//  Write port:
//   - A write is accepted when wr_valid & wr_ready.
//   - shadow[wr_idx] <= (wr_val > MAX_VAL) ? 0 : wr_val.
//   - wr_ready = (state==IDLE) & ~rst.
//  clr_req:
//   - In IDLE, zeros the shadow buffer next cycle.
//   - If asserted in the same cycle as an accepted write, the clear wins.
//   - Ignored outside IDLE.
//  FSM states IDLE, PENDING, COPY:
//   - IDLE -> PENDING on commit_req. A write, clear or both in the same cycle are applied first and included in the commit.
//   - PENDING -> COPY in the cycle frame_tick=1. commit_req in PENDING/COPY is ignored (no queueing).
//   - COPY -> IDLE. In COPY, board_vals <= shadow and commit_ack <= 1.
//   - Timing: board_vals changes and commit_ack pulses in the cycle after COPY.
//  Outputs and latency:
//   - busy = (state != IDLE), registered with the state.
//   - Latency from frame_tick to new board_vals is 2 cycles, well inside vblank.
//   - If commit_req arrives in the same cycle as frame_tick, the commit waits for the next frame.
//  board_vals changes only on COPY or reset; never mid-frame.
//  rst mid-PENDING/COPY: commit dropped, no commit_ack, both buffers cleared.
// STRUCTURE
//  game_pkg:
//   - N_TILES, VAL_W, MAX_VAL, V_ACTIVE, BLANK_VAL=0.
//   - typedef tile_val_t (logic [VAL_W-1:0]).
//   - typedef enum {IDLE, PENDING, COPY} sync_state_t.
//  Sub-module vblank_detect (cond, edge, registered frame_tick); the rest is flat.
// TESTING
//  1. Reset, write idx5=3, commit, run to vblank
//     -> board_vals[23:20]=3 exactly 2 cycles after frame_tick; commit_ack one pulse; all other tiles 0.
//  2. Write idx0=14 and idx15=13, commit
//     -> tile0 displays 0, tile15 displays 13.
//  3. commit_req pending, drive wr_valid
//     -> wr_ready=0 until the cycle after commit_ack; the write lands after it; board_vals unchanged mid-frame.
//  4. Hold counters at (0,480) for 5 clocks -> exactly one frame_tick.
//  5. Same cycle: write idx2=7, clr_req, commit_req -> after vblank all tiles 0.
//  6. Assert rst during PENDING
//     -> no commit_ack, board_vals all 0, wr_ready=1 in the first cycle after rst drops.

Source files
------------

// File: rtl/board_frame_sync_pkg.sv
// Shared constants and types for the board frame synchroniser.
// The exponent clamp helper keeps illegal values from ever reaching the display.
package board_frame_sync_pkg;

    localparam int N_TILES  = 16;
    localparam int VAL_W    = 4;
    localparam int MAX_VAL  = 13;
    localparam int V_ACTIVE = 480;
    localparam int IDX_W    = 4;
    localparam int CNT_W    = 10;

    typedef logic [VAL_W-1:0] tile_val_t;

    localparam tile_val_t BLANK_VAL = '0;

    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        COPY
    } sync_state_t;

    // Out-of-range exponents are stored as an empty tile.
    function automatic tile_val_t clamp_val(input tile_val_t v);
        return (int'(v) > MAX_VAL) ? BLANK_VAL : v;
    endfunction

endpackage

// File: rtl/board_frame_sync_if.sv
// Tile write port between the game FSM (master) and the shadow buffer (slave).
interface board_frame_sync_if;
    import board_frame_sync_pkg::*;

    logic             wr_valid;
    logic             wr_ready;
    logic [IDX_W-1:0] wr_idx;
    tile_val_t        wr_val;

    modport master (output wr_valid, output wr_idx, output wr_val, input wr_ready);
    modport slave  (input wr_valid, input wr_idx, input wr_val, output wr_ready);

endinterface

// File: rtl/board_frame_sync_vblank_detect.sv
// Produces a single registered pulse at the first clock of vertical blanking,
// even when the VGA counters hold their value for several clocks.
module board_frame_sync_vblank_detect
    import board_frame_sync_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] counter_x,
    input  logic [CNT_W-1:0] counter_y,
    output logic             frame_tick
);

    logic cond;
    logic cond_q;
    logic frame_tick_q;

    assign cond = (counter_y == CNT_W'(V_ACTIVE)) && (counter_x == '0);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the clock edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            cond_q       <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            cond_q       <= cond;
            frame_tick_q <= cond & ~cond_q;
        end
    end

    assign frame_tick = frame_tick_q;

endmodule

// File: rtl/board_frame_sync.sv
// Shadow/display double buffer for the 4x4 tile board: writes land in the shadow,
// and a commit publishes the whole board at the start of vblank so nothing tears.
module board_frame_sync
    import board_frame_sync_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CNT_W-1:0]         counter_x,
    input  logic [CNT_W-1:0]         counter_y,
    board_frame_sync_if.slave        wr,
    input  logic                     clr_req,
    input  logic                     commit_req,
    output logic                     commit_ack,
    output logic                     busy,
    output logic                     frame_tick,
    output logic [N_TILES*VAL_W-1:0] board_vals
);

    sync_state_t              state_q;
    tile_val_t                shadow_q [N_TILES];
    logic [N_TILES*VAL_W-1:0] board_q;
    logic                     ack_q;
    logic                     busy_q;

    board_frame_sync_vblank_detect u_vblank (
        .clk        (clk),
        .rst        (rst),
        .counter_x  (counter_x),
        .counter_y  (counter_y),
        .frame_tick (frame_tick)
    );

    // NOTE: both tile buffers are reset explicitly; the board must read as empty
    // after reset, so they cannot be left as reset-less storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
            board_q <= '0;
            for (int i = 0; i < N_TILES; i++) shadow_q[i] <= BLANK_VAL;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // Clear beats a simultaneous write; both land before a same-cycle commit.
                    if (clr_req) begin
                        for (int i = 0; i < N_TILES; i++) shadow_q[i] <= BLANK_VAL;
                    end else if (wr.wr_valid) begin
                        shadow_q[wr.wr_idx] <= clamp_val(wr.wr_val);
                    end
                    if (commit_req) begin
                        state_q <= PENDING;
                        busy_q  <= 1'b1;
                    end
                end
                PENDING: begin
                    if (frame_tick) state_q <= COPY;
                end
                COPY: begin
                    for (int i = 0; i < N_TILES; i++) board_q[i*VAL_W +: VAL_W] <= shadow_q[i];
                    ack_q   <= 1'b1;
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign wr.wr_ready = (state_q == IDLE) & ~rst;
    assign commit_ack  = ack_q;
    assign busy        = busy_q;
    assign board_vals  = board_q;

endmodule

// File: tb/tb_board_frame_sync.sv
// Self-checking bench for board_frame_sync: a tile model plus a queue of expected
// boards, one entry per accepted commit, compared whenever commit_ack pulses.
module tb_board_frame_sync;
    import board_frame_sync_pkg::*;

    logic             clk;
    logic             rst;
    logic [CNT_W-1:0] counter_x;
    logic [CNT_W-1:0] counter_y;
    logic             clr_req;
    logic             commit_req;
    logic             commit_ack;
    logic             busy;
    logic             frame_tick;
    logic [63:0]      board_vals;

    board_frame_sync_if wr_if ();

    board_frame_sync dut (
        .clk        (clk),
        .rst        (rst),
        .counter_x  (counter_x),
        .counter_y  (counter_y),
        .wr         (wr_if),
        .clr_req    (clr_req),
        .commit_req (commit_req),
        .commit_ack (commit_ack),
        .busy       (busy),
        .frame_tick (frame_tick),
        .board_vals (board_vals)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          tests = 0;
    int          fails = 0;
    int          ack_count = 0;
    int          tick_count = 0;
    logic [63:0] sb [$];
    logic [3:0]  m_shadow [16];
    logic [63:0] m_board;

    typedef struct {
        logic [3:0] idx;
        logic [3:0] val;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] pack_shadow();
        logic [63:0] r;
        for (int i = 0; i < 16; i++) r[i*4 +: 4] = m_shadow[i];
        return r;
    endfunction

    function automatic logic [3:0] model_clamp(input logic [3:0] v);
        return (v > 4'd13) ? 4'd0 : v;
    endfunction

    // Scoreboard: every commit_ack must match the oldest outstanding commit.
    always @(negedge clk) begin
        if (frame_tick) tick_count++;
        if (commit_ack) begin
            ack_count++;
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected commit_ack: board %0h with no commit outstanding", board_vals);
            end else begin
                check("board_vals at commit_ack", board_vals, sb.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [3:0] idx, input logic [3:0] val);
        wr_if.wr_valid = 1'b1;
        wr_if.wr_idx   = idx;
        wr_if.wr_val   = val;
        @(negedge clk);
        check("wr_ready in IDLE", wr_if.wr_ready, 1'b1);
        step();
        wr_if.wr_valid = 1'b0;
        m_shadow[idx] = model_clamp(val);
    endtask

    task automatic do_commit();
        commit_req = 1'b1;
        step();
        commit_req = 1'b0;
        sb.push_back(pack_shadow());
    endtask

    task automatic vblank(input int hold);
        counter_y = CNT_W'(V_ACTIVE);
        counter_x = '0;
        repeat (hold) step();
        counter_y = '0;
        counter_x = 10'd1;
    endtask

    task automatic wait_ack(input int bound);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            if (commit_ack) seen = 1'b1;
        end
        check("commit_ack arrives within bound", seen, 1'b1);
        m_board = pack_shadow();
        step();
    endtask

    initial begin
        logic        acc;
        logic        seen_ack;
        int          acks_before;
        int          ticks_before;

        rst = 1'b1;
        counter_x = 10'd1;
        counter_y = '0;
        clr_req = 1'b0;
        commit_req = 1'b0;
        wr_if.wr_valid = 1'b0;
        wr_if.wr_idx = '0;
        wr_if.wr_val = '0;
        for (int i = 0; i < 16; i++) m_shadow[i] = 4'd0;
        m_board = '0;

        // Reset state
        step();
        step();
        @(negedge clk);
        check("reset wr_ready", wr_if.wr_ready, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset commit_ack", commit_ack, 1'b0);
        check("reset frame_tick", frame_tick, 1'b0);
        check("reset board_vals", board_vals, 64'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("wr_ready first cycle after reset", wr_if.wr_ready, 1'b1);
        step();

        // 1: single write, commit, exact vblank timing
        do_write(4'd5, 4'd3);
        do_commit();
        vblank(1);
        @(negedge clk);
        check("t1 frame_tick", frame_tick, 1'b1);
        check("t1 busy while pending", busy, 1'b1);
        check("t1 board old at tick", board_vals, 64'd0);
        step();
        @(negedge clk);
        check("t1 tick one cycle", frame_tick, 1'b0);
        check("t1 wr_ready in COPY", wr_if.wr_ready, 1'b0);
        check("t1 board old in COPY", board_vals, 64'd0);
        check("t1 no ack yet", commit_ack, 1'b0);
        step();
        @(negedge clk);
        check("t1 commit_ack +2", commit_ack, 1'b1);
        check("t1 board +2", board_vals, 64'h0000_0000_0030_0000);
        check("t1 busy clear", busy, 1'b0);
        step();
        @(negedge clk);
        check("t1 ack single pulse", commit_ack, 1'b0);
        m_board = pack_shadow();
        step();

        // 2: table of writes including out-of-range clamps
        vecs[0] = '{idx: 4'd0,  val: 4'd14, exp: 4'd0};
        vecs[1] = '{idx: 4'd15, val: 4'd13, exp: 4'd13};
        vecs[2] = '{idx: 4'd3,  val: 4'd15, exp: 4'd0};
        vecs[3] = '{idx: 4'd7,  val: 4'd1,  exp: 4'd1};
        vecs[4] = '{idx: 4'd9,  val: 4'd12, exp: 4'd12};
        vecs[5] = '{idx: 4'd10, val: 4'd0,  exp: 4'd0};
        vecs[6] = '{idx: 4'd12, val: 4'd8,  exp: 4'd8};
        vecs[7] = '{idx: 4'd5,  val: 4'd14, exp: 4'd0};
        for (int i = 0; i < 8; i++) do_write(vecs[i].idx, vecs[i].val);
        do_commit();
        vblank(1);
        wait_ack(8);
        for (int i = 0; i < 8; i++) begin
            logic [3:0] t;
            t = board_vals[vecs[i].idx*4 +: 4];
            check($sformatf("t2 tile %0d", vecs[i].idx), t, vecs[i].exp);
        end

        // 3: writes stall while a commit is in flight; extra commit_req ignored
        do_commit();
        wr_if.wr_valid = 1'b1;
        wr_if.wr_idx = 4'd1;
        wr_if.wr_val = 4'd9;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t3 wr_ready low while pending", wr_if.wr_ready, 1'b0);
            check("t3 board steady while pending", board_vals, m_board);
            commit_req = (i == 1);
            step();
        end
        commit_req = 1'b0;
        vblank(1);
        acc = 1'b0;
        seen_ack = 1'b0;
        for (int i = 0; i < 12 && !acc; i++) begin
            @(negedge clk);
            if (commit_ack) seen_ack = 1'b1;
            if (wr_if.wr_ready) begin
                acc = 1'b1;
                check("t3 write held until commit_ack", seen_ack, 1'b1);
            end else begin
                check("t3 board steady before COPY", board_vals, m_board);
            end
            step();
        end
        check("t3 write eventually accepted", acc, 1'b1);
        wr_if.wr_valid = 1'b0;
        m_board = pack_shadow();
        m_shadow[1] = 4'd9;
        repeat (4) step();
        check("t3 single ack despite second commit_req", sb.size(), 0);
        check("t3 board unchanged by late write", board_vals, m_board);
        do_commit();
        vblank(1);
        wait_ack(8);
        check("t3 late write published", board_vals[7:4], 4'd9);

        // 4: counters held at vblank start for 5 clocks
        ticks_before = tick_count;
        vblank(5);
        repeat (3) step();
        check("t4 one frame_tick per frame", tick_count - ticks_before, 1);

        // commit_req coincident with frame_tick waits for the next frame
        acks_before = ack_count;
        vblank(1);
        @(negedge clk);
        check("coincident frame_tick", frame_tick, 1'b1);
        do_commit();
        repeat (6) step();
        check("commit skips coincident frame", ack_count - acks_before, 0);
        vblank(1);
        wait_ack(8);

        // 5: write, clear and commit in the same cycle
        wr_if.wr_valid = 1'b1;
        wr_if.wr_idx = 4'd2;
        wr_if.wr_val = 4'd7;
        clr_req = 1'b1;
        for (int i = 0; i < 16; i++) m_shadow[i] = 4'd0;
        do_commit();
        wr_if.wr_valid = 1'b0;
        clr_req = 1'b0;
        vblank(1);
        wait_ack(8);
        check("t5 clear wins", board_vals, 64'd0);

        // 6: reset while a commit is pending
        do_write(4'd4, 4'd6);
        do_write(4'd11, 4'd2);
        do_commit();
        repeat (2) step();
        rst = 1'b1;
        step();
        @(negedge clk);
        check("t6 wr_ready low in reset", wr_if.wr_ready, 1'b0);
        step();
        rst = 1'b0;
        sb.delete();
        for (int i = 0; i < 16; i++) m_shadow[i] = 4'd0;
        m_board = '0;
        acks_before = ack_count;
        @(negedge clk);
        check("t6 wr_ready after reset", wr_if.wr_ready, 1'b1);
        check("t6 busy after reset", busy, 1'b0);
        step();
        vblank(1);
        repeat (6) step();
        check("t6 commit dropped", ack_count - acks_before, 0);
        check("t6 board cleared", board_vals, 64'd0);
        do_commit();
        vblank(1);
        wait_ack(8);
        check("t6 shadow cleared", board_vals, 64'd0);

        check("scoreboard drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
